// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex driver for an N-digit seven-segment display.
// One digit is driven per slot of DIV cycles. The first BLANK_CYCLES of each
// slot keep every anode off so the previous digit's pattern cannot ghost onto
// the next one. The displayed value is snapshotted once per frame so that a
// whole scan shows a single consistent number.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap_val;
  logic [NUM_DIGITS-1:0]   snap_dp;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              nib;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              lit_seg;
  logic                    lit_dp;
  logic [NUM_DIGITS-1:0]   lit_an;

  // Hex to segment pattern, logical lit = 1, bit 6 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = en && slot_end && (idx == IDX_LAST);

  // Next-cycle drive in logical (lit = 1) form; polarity is applied at the register.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    lit_seg    = '0;
    lit_dp     = 1'b0;
    lit_an     = '0;
    nib        = 4'(snap_val >> {idx, 2'b00});
    // Walk from the most significant digit down; a digit blanks only while
    // everything above it (and itself) is zero. Digit 0 always shows.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (snap_val[4*i +: 4] == 4'h0);
      blank[i]   = lz_blank && (i != 0) && zero_above;
    end
    if (en && (pre >= PRE_BLANK)) begin
      lit_an[idx] = 1'b1;
      lit_seg     = blank[idx] ? 7'h00 : hex_to_seg(nib);
      lit_dp      = snap_dp[idx];
    end
  end

  // Prescaler, digit index, frame snapshot and registered pin drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre       <= '0;
      idx       <= '0;
      snap_val  <= value;
      snap_dp   <= dp_in;
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
      digit_idx <= '0;
    end else begin
      seg       <= lit_seg ^ {7{SEG_ACTIVE_LOW}};
      dp        <= lit_dp ^ SEG_ACTIVE_LOW;
      an        <= lit_an ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      digit_idx <= idx;
      if (en) begin
        if (slot_end) begin
          pre <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
      if (frame_end) begin
        snap_val <= value;
        snap_dp  <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: an active-low and an active-high instance
// share the same stimulus and are compared against a time-based display model.
module tb_sevenseg_scan_driver;

  localparam int ND    = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = ND * DIV;

  logic        clk = 1'b0;
  logic        reset, en, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [6:0] seg_lo, seg_hi;
  logic       dp_lo, dp_hi;
  logic [3:0] an_lo, an_hi;
  logic [1:0] didx_lo, didx_hi;

  int total = 0;
  int bad   = 0;

  // model state: enabled cycles since reset and the frame snapshot
  int          m_t;
  logic [15:0] m_snap;
  logic [3:0]  m_snapdp;
  int          exp_t;
  logic [13:0] want_lo, want_hi;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYCLES(BLANK),
                         .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .en(en), .value(value), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg_lo), .dp(dp_lo), .an(an_lo), .digit_idx(didx_lo));

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYCLES(BLANK),
                         .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .en(en), .value(value), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg(seg_hi), .dp(dp_hi), .an(an_hi), .digit_idx(didx_hi));

  always #5 clk = ~clk;

  // One clock: predict the next outputs from the model, clock, update the model.
  task automatic tick();
    int          ph, sl;
    logic [15:0] sh;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic [1:0]  e_idx;
    ph = m_t % DIV;
    sl = (m_t / DIV) % ND;
    exp_t = m_t;
    e_seg = '0; e_dp = 1'b0; e_an = '0; e_idx = '0;
    if (!reset) begin
      e_idx = 2'(sl);
      if (en && ph >= BLANK) begin
        e_an = 4'(1 << sl);
        sh   = m_snap >> (4 * sl);
        if (lz_blank && sl >= 1 && sh == 16'h0) e_seg = '0;
        else e_seg = seg_tab[sh[3:0]];
        e_dp = m_snapdp[sl];
      end
    end
    want_hi = {e_seg, e_dp, e_an, e_idx};
    want_lo = {~e_seg, ~e_dp, ~e_an, e_idx};
    @(posedge clk);
    if (reset) begin
      m_t = 0; m_snap = value; m_snapdp = dp_in;
    end else if (en) begin
      if (ph == DIV - 1 && sl == ND - 1) begin
        m_snap = value; m_snapdp = dp_in;
      end
      m_t++;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; value = 16'hABCD; dp_in = 4'hF; lz_blank = 1'b0;
    do_reset(3);
    total++;
    if (seg_lo !== 7'h7F || dp_lo !== 1'b1 || an_lo !== 4'hF || didx_lo !== 2'd0) begin
      bad++;
      $display("FAIL reset_lo got seg=%h dp=%b an=%h idx=%0d want 7f 1 f 0", seg_lo, dp_lo, an_lo, didx_lo);
    end
    total++;
    if ({seg_hi, dp_hi, an_hi, didx_hi} !== want_hi) begin
      bad++;
      $display("FAIL reset_hi got %h want %h", {seg_hi, dp_hi, an_hi, didx_hi}, want_hi);
    end
  endtask

  task automatic test_scan_order();
    logic [6:0] want;
    value = 16'h12AF; dp_in = 4'h0; lz_blank = 1'b0; en = 1'b1;
    do_reset(1);
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      total++;
      if ({seg_lo, dp_lo, an_lo, didx_lo} !== want_lo || {seg_hi, dp_hi, an_hi, didx_hi} !== want_hi) begin
        bad++;
        $display("FAIL scan_model t=%0d got %h/%h want %h/%h", exp_t,
                 {seg_lo, dp_lo, an_lo, didx_lo}, {seg_hi, dp_hi, an_hi, didx_hi}, want_lo, want_hi);
      end
      case (an_lo)
        4'hE: want = ~7'b1000111;
        4'hD: want = ~7'b1110111;
        4'hB: want = ~7'b1101101;
        4'h7: want = ~7'b0110000;
        default: want = 7'h7F;
      endcase
      total++;
      if (seg_lo !== want || (an_lo == 4'hF) !== ((exp_t % DIV) == 0)) begin
        bad++;
        $display("FAIL scan_order t=%0d got an=%h seg=%h want seg=%h", exp_t, an_lo, seg_lo, want);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] vals [3] = '{16'h0007, 16'h0000, 16'h0100};
    logic [6:0]  want;
    lz_blank = 1'b1; dp_in = 4'h0; en = 1'b1;
    for (int v = 0; v < 3; v++) begin
      value = vals[v];
      do_reset(1);
      for (int c = 0; c < FRAME; c++) begin
        tick();
        total++;
        if ({seg_lo, dp_lo, an_lo, didx_lo} !== want_lo || {seg_hi, dp_hi, an_hi, didx_hi} !== want_hi) begin
          bad++;
          $display("FAIL lz_model v=%h t=%0d got %h want %h", vals[v], exp_t, {seg_lo, dp_lo, an_lo, didx_lo}, want_lo);
        end
        want = 7'h7F;
        case (vals[v])
          16'h0007: if (an_lo == 4'hE) want = ~7'b1110000;
          16'h0000: if (an_lo == 4'hE) want = ~7'b1111110;
          default: begin
            if (an_lo == 4'hE || an_lo == 4'hD) want = ~7'b1111110;
            if (an_lo == 4'hB) want = ~7'b0110000;
          end
        endcase
        total++;
        if (seg_lo !== want) begin
          bad++;
          $display("FAIL lz_digit v=%h an=%h got seg=%h want %h", vals[v], an_lo, seg_lo, want);
        end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_frame_consistency();
    logic [6:0] want;
    value = 16'h1111; dp_in = 4'h0; lz_blank = 1'b0; en = 1'b1;
    do_reset(1);
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == DIV + 1) value = 16'h2222;
      tick();
      total++;
      if ({seg_lo, dp_lo, an_lo, didx_lo} !== want_lo) begin
        bad++;
        $display("FAIL frame_model t=%0d got %h want %h", exp_t, {seg_lo, dp_lo, an_lo, didx_lo}, want_lo);
      end
      want = (an_lo == 4'hF) ? 7'h7F : (exp_t < FRAME ? ~7'b0110000 : ~7'b1101101);
      total++;
      if (seg_lo !== want) begin
        bad++;
        $display("FAIL frame_hold t=%0d got seg=%h want %h", exp_t, seg_lo, want);
      end
    end
  endtask

  task automatic test_dp_enable();
    value = 16'h3456; dp_in = 4'b0101; lz_blank = 1'b0; en = 1'b1;
    do_reset(1);
    for (int c = 0; c < 2 * FRAME + 10; c++) begin
      en = !(c >= 6 && c < 16);
      tick();
      total++;
      if ({seg_lo, dp_lo, an_lo, didx_lo} !== want_lo || {seg_hi, dp_hi, an_hi, didx_hi} !== want_hi) begin
        bad++;
        $display("FAIL dp_model t=%0d got %h want %h", exp_t, {seg_lo, dp_lo, an_lo, didx_lo}, want_lo);
      end
      total++;
      if ((!en && an_lo !== 4'hF) || dp_lo !== !(an_lo == 4'hE || an_lo == 4'hB)) begin
        bad++;
        $display("FAIL dp_en t=%0d en=%b got an=%h dp=%b", exp_t, en, an_lo, dp_lo);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_midscan();
    value = 16'h9876; dp_in = 4'h0; en = 1'b1;
    do_reset(1);
    for (int c = 0; c < 2 * DIV + 2; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (an_lo !== 4'hF || didx_lo !== 2'd0 || an_hi !== 4'h0) begin
      bad++;
      $display("FAIL reset_mid got an=%h idx=%0d an_hi=%h want f 0 0", an_lo, didx_lo, an_hi);
    end
    for (int c = 0; c < DIV + 1; c++) begin
      tick();
      total++;
      if ({seg_lo, dp_lo, an_lo, didx_lo} !== want_lo || {seg_hi, dp_hi, an_hi, didx_hi} !== want_hi) begin
        bad++;
        $display("FAIL reset_resume t=%0d got %h want %h", exp_t, {seg_lo, dp_lo, an_lo, didx_lo}, want_lo);
      end
    end
  endtask

  task automatic test_polarity();
    value = 16'h8888; dp_in = 4'h0; lz_blank = 1'b0; en = 1'b1;
    do_reset(1);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      total++;
      if (an_hi != 4'h0 && (seg_hi !== 7'h7F || !$onehot(an_hi))) begin
        bad++;
        $display("FAIL polarity t=%0d got seg=%h an=%h want 7f one-hot", exp_t, seg_hi, an_hi);
      end
      total++;
      if ({seg_hi, dp_hi, an_hi, didx_hi} !== want_hi) begin
        bad++;
        $display("FAIL polarity_model t=%0d got %h want %h", exp_t, {seg_hi, dp_hi, an_hi, didx_hi}, want_hi);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 9) != 0);
      lz_blank = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 5) == 0) value = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom);
      dp_in = 4'($urandom);
      tick();
      total++;
      if ({seg_lo, dp_lo, an_lo, didx_lo} !== want_lo || {seg_hi, dp_hi, an_hi, didx_hi} !== want_hi) begin
        bad++;
        $display("FAIL random c=%0d got %h/%h want %h/%h", c,
                 {seg_lo, dp_lo, an_lo, didx_lo}, {seg_hi, dp_hi, an_hi, didx_hi}, want_lo, want_hi);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; lz_blank = 1'b0; value = '0; dp_in = '0;
    m_t = 0; m_snap = '0; m_snapdp = '0; exp_t = 0;
    want_lo = '0; want_hi = '0;
    test_reset();
    test_scan_order();
    test_lz_blank();
    test_frame_consistency();
    test_dp_enable();
    test_reset_midscan();
    test_polarity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
